// File: rtl/cache_bus_responder.sv
// Memory-side burst responder: word-addressed array served over independent read and write
// burst channels with configurable first-beat latency and inter-beat gaps.
module cache_bus_responder #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1,
    parameter int unsigned BEAT_GAP      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [3:0]  sel_i,
    input  logic        ren_i,
    input  logic        rready_i,
    input  logic [31:0] raddr_i,
    input  logic [3:0]  rlen_i,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    input  logic        wen_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic        wvalid_i,
    input  logic        wlast_i,
    input  logic [3:0]  wlen_i,
    output logic        wdata_resp_o,
    output logic        protocol_err_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    // Wait counters are loaded with N-1 so a count of N yields the first beat in cycle N+1.
    localparam logic [3:0] RD_LOAD  = 4'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD  = 4'((WRITE_LATENCY == 0) ? 0 : WRITE_LATENCY - 1);
    localparam logic [3:0] GAP_LOAD = 4'((BEAT_GAP == 0) ? 0 : BEAT_GAP - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

    logic [31:0] r_mem [DEPTH];

    rd_state_e           r_rstate, w_rstate_d;
    logic [31:0]         r_rstart, w_rstart_d;
    logic [3:0]          r_rlast, w_rlast_d;
    logic [3:0]          r_rk, w_rk_d;
    logic [3:0]          r_rcnt, w_rcnt_d;
    logic [31:0]         r_rdata, w_rdata_d;
    logic                r_rvalid, w_rvalid_d;
    logic                w_rerr;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic [31:0]         w_rd_word;
    logic [31:0]         w_rexp_addr;
    logic [3:0]          w_rk_inc;

    wr_state_e           r_wstate, w_wstate_d;
    logic [31:0]         r_wstart, w_wstart_d;
    logic [3:0]          r_wlast, w_wlast_d;
    logic [3:0]          r_wk, w_wk_d;
    logic [3:0]          r_wcnt, w_wcnt_d;
    logic                r_wresp, w_wresp_d;
    logic                w_werr;
    logic                w_mem_we;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic [31:0]         w_wexp_addr;

    logic                r_perr;

    assign w_rk_inc    = r_rk + 4'd1;
    assign w_rexp_addr = r_rstart + {26'b0, r_rk, 2'b00};
    assign w_wexp_addr = r_wstart + {26'b0, r_wk, 2'b00};
    assign w_wr_idx    = waddr_i[ADDR_WIDTH+1:2];

    // Word fetched for the beat being presented at the end of this cycle.
    always_comb begin
        w_rd_idx = r_rstart[ADDR_WIDTH+1:2] + ADDR_WIDTH'(r_rk);
        unique case (r_rstate)
            R_IDLE:  w_rd_idx = raddr_i[ADDR_WIDTH+1:2];
            R_BEAT:  w_rd_idx = r_rstart[ADDR_WIDTH+1:2] + ADDR_WIDTH'(w_rk_inc);
            default: w_rd_idx = r_rstart[ADDR_WIDTH+1:2] + ADDR_WIDTH'(r_rk);
        endcase
    end

    assign w_rd_word = r_mem[w_rd_idx];

    always_comb begin
        w_rstate_d = r_rstate;
        w_rstart_d = r_rstart;
        w_rlast_d  = r_rlast;
        w_rk_d     = r_rk;
        w_rcnt_d   = r_rcnt;
        w_rdata_d  = r_rdata;
        w_rvalid_d = r_rvalid;
        w_rerr     = 1'b0;
        unique case (r_rstate)
            R_IDLE: begin
                if (ren_i && ce_i) begin
                    w_rstart_d = raddr_i;
                    w_rlast_d  = rlen_i;
                    w_rk_d     = 4'd0;
                    if (READ_LATENCY == 0) begin
                        w_rdata_d  = w_rd_word;
                        w_rvalid_d = 1'b1;
                        w_rstate_d = R_BEAT;
                    end else begin
                        w_rcnt_d   = RD_LOAD;
                        w_rstate_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (!ren_i) begin
                    w_rerr     = 1'b1;
                    w_rvalid_d = 1'b0;
                    w_rstate_d = R_IDLE;
                end else if (r_rcnt == 4'd0) begin
                    w_rdata_d  = w_rd_word;
                    w_rvalid_d = 1'b1;
                    w_rstate_d = R_BEAT;
                end else begin
                    w_rcnt_d = r_rcnt - 4'd1;
                end
            end
            R_BEAT: begin
                if (!ren_i) begin
                    w_rerr     = 1'b1;
                    w_rvalid_d = 1'b0;
                    w_rstate_d = R_IDLE;
                end else if (r_rvalid && rready_i) begin
                    if (raddr_i != w_rexp_addr) begin
                        w_rerr = 1'b1;
                    end
                    if (r_rk == r_rlast) begin
                        w_rvalid_d = 1'b0;
                        w_rstate_d = R_IDLE;
                    end else begin
                        w_rk_d = w_rk_inc;
                        if (BEAT_GAP == 0) begin
                            w_rdata_d = w_rd_word;
                        end else begin
                            w_rvalid_d = 1'b0;
                            w_rcnt_d   = GAP_LOAD;
                            w_rstate_d = R_WAIT;
                        end
                    end
                end
            end
            default: begin
                w_rvalid_d = 1'b0;
                w_rstate_d = R_IDLE;
            end
        endcase
    end

    always_comb begin
        w_wstate_d = r_wstate;
        w_wstart_d = r_wstart;
        w_wlast_d  = r_wlast;
        w_wk_d     = r_wk;
        w_wcnt_d   = r_wcnt;
        w_wresp_d  = r_wresp;
        w_werr     = 1'b0;
        w_mem_we   = 1'b0;
        unique case (r_wstate)
            W_IDLE: begin
                if (wen_i && ce_i) begin
                    w_wstart_d = waddr_i;
                    w_wlast_d  = wlen_i;
                    w_wk_d     = 4'd0;
                    if (WRITE_LATENCY == 0) begin
                        w_wresp_d  = 1'b1;
                        w_wstate_d = W_RESP;
                    end else begin
                        w_wcnt_d   = WR_LOAD;
                        w_wstate_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (!wen_i) begin
                    w_werr     = 1'b1;
                    w_wresp_d  = 1'b0;
                    w_wstate_d = W_IDLE;
                end else if (r_wcnt == 4'd0) begin
                    w_wresp_d  = 1'b1;
                    w_wstate_d = W_RESP;
                end else begin
                    w_wcnt_d = r_wcnt - 4'd1;
                end
            end
            W_RESP: begin
                w_wresp_d = 1'b0;
                if (!wen_i) begin
                    w_werr     = 1'b1;
                    w_wstate_d = W_IDLE;
                end else begin
                    if ((waddr_i != w_wexp_addr) || (wlast_i != (r_wk == r_wlast))) begin
                        w_werr = 1'b1;
                    end
                    if (!wvalid_i) begin
                        w_werr     = 1'b1;
                        w_wstate_d = W_IDLE;
                    end else begin
                        w_mem_we = 1'b1;
                        if (r_wk == r_wlast) begin
                            w_wstate_d = W_IDLE;
                        end else begin
                            w_wk_d = r_wk + 4'd1;
                            if (BEAT_GAP == 0) begin
                                w_wresp_d = 1'b1;
                            end else begin
                                w_wcnt_d   = GAP_LOAD;
                                w_wstate_d = W_WAIT;
                            end
                        end
                    end
                end
            end
            default: begin
                w_wresp_d  = 1'b0;
                w_wstate_d = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rstart <= '0;
            r_rlast  <= '0;
            r_rk     <= '0;
            r_rcnt   <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_wstate <= W_IDLE;
            r_wstart <= '0;
            r_wlast  <= '0;
            r_wk     <= '0;
            r_wcnt   <= '0;
            r_wresp  <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_rstate <= w_rstate_d;
            r_rstart <= w_rstart_d;
            r_rlast  <= w_rlast_d;
            r_rk     <= w_rk_d;
            r_rcnt   <= w_rcnt_d;
            r_rdata  <= w_rdata_d;
            r_rvalid <= w_rvalid_d;
            r_wstate <= w_wstate_d;
            r_wstart <= w_wstart_d;
            r_wlast  <= w_wlast_d;
            r_wk     <= w_wk_d;
            r_wcnt   <= w_wcnt_d;
            r_wresp  <= w_wresp_d;
            r_perr   <= r_perr | w_rerr | w_werr;
        end
    end

    // Array is deliberately not reset; a same-cycle read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_i[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o        = r_rdata;
    assign rdata_valid_o  = r_rvalid;
    assign wdata_resp_o   = r_wresp;
    assign protocol_err_o = r_perr;

endmodule

// File: tb/tb_cache_bus_responder.sv
// Bench for cache_bus_responder: a default instance and a BEAT_GAP=2 instance, checked against
// a word-array model and beat timing derived from latency/gap arithmetic.
module tb_cache_bus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce, ren, rready, wen, wvalid, wlast, tgt;
    logic [3:0]  sel, rlen, wlen;
    logic [31:0] raddr, waddr, wdata;

    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1, wresp0, wresp1, perr0, perr1;
    logic [31:0] o_rdata;
    logic        o_rvalid, o_wresp, o_perr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [2][1024];

    always #5 clk = ~clk;

    cache_bus_responder u_dut0 (
        .clk(clk), .rst(rst), .ce_i(ce), .sel_i(sel), .ren_i(ren & ~tgt), .rready_i(rready),
        .raddr_i(raddr), .rlen_i(rlen), .rdata_o(rdata0), .rdata_valid_o(rvalid0),
        .wen_i(wen & ~tgt), .waddr_i(waddr), .wdata_i(wdata), .wvalid_i(wvalid),
        .wlast_i(wlast), .wlen_i(wlen), .wdata_resp_o(wresp0), .protocol_err_o(perr0)
    );

    cache_bus_responder #(.BEAT_GAP(2)) u_dut1 (
        .clk(clk), .rst(rst), .ce_i(ce), .sel_i(sel), .ren_i(ren & tgt), .rready_i(rready),
        .raddr_i(raddr), .rlen_i(rlen), .rdata_o(rdata1), .rdata_valid_o(rvalid1),
        .wen_i(wen & tgt), .waddr_i(waddr), .wdata_i(wdata), .wvalid_i(wvalid),
        .wlast_i(wlast), .wlen_i(wlen), .wdata_resp_o(wresp1), .protocol_err_o(perr1)
    );

    assign o_rdata  = tgt ? rdata1  : rdata0;
    assign o_rvalid = tgt ? rvalid1 : rvalid0;
    assign o_wresp  = tgt ? wresp1  : wresp0;
    assign o_perr   = tgt ? perr1   : perr0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read burst; first beat due in cycle READ_LATENCY+1, later beats GAP+1 after acceptance.
    task automatic read_burst(input logic [31:0] start, input int len, input int stall_pct,
                              input int rst_beat);
        int   cyc, k, nv, gap, idx;
        logic exp_v;
        gap = tgt ? 2 : 0;
        nv  = 3;
        cyc = 0;
        k   = 0;
        @(posedge clk); #1;
        ren  = 1'b1;
        rlen = 4'(len - 1);
        while (k < len && cyc < 300) begin
            raddr  = start + 32'(4 * k);
            rready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            exp_v = (cyc >= nv);
            chk("rd_valid", 32'(o_rvalid), 32'(exp_v));
            if (exp_v) begin
                idx = int'(((start >> 2) + 32'(k)) & 32'h3FF);
                chk("rd_data", o_rdata, model[tgt][idx]);
                if (k == rst_beat) begin
                    #1 rst = 1'b1;
                    #1;
                    chk("rst_rvalid", 32'(o_rvalid), 32'd0);
                    chk("rst_rdata", o_rdata, 32'd0);
                    chk("rst_wresp", 32'(o_wresp), 32'd0);
                    chk("rst_perr", 32'(o_perr), 32'd0);
                    return;
                end
                if (rready) begin
                    k++;
                    nv = cyc + gap + 1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("rd_beats", 32'(k), 32'(len));
        ren    = 1'b0;
        rready = 1'b0;
        @(negedge clk);
        chk("rd_idle", 32'(o_rvalid), 32'd0);
    endtask

    // Write burst; response pulses timed like read beats, model updated on each pulse.
    task automatic write_burst(input logic [31:0] start, input int len, input logic [3:0] s,
                               input bit rnd, input logic [31:0] dbase, input int last_mark);
        int          cyc, k, nv, gap, idx;
        logic [31:0] d;
        logic        ev;
        gap = tgt ? 2 : 0;
        nv  = 2;
        cyc = 0;
        k   = 0;
        @(posedge clk); #1;
        wen    = 1'b1;
        wlen   = 4'(len - 1);
        sel    = s;
        wvalid = 1'b1;
        while (k < len && cyc < 300) begin
            waddr = start + 32'(4 * k);
            d     = rnd ? $urandom : dbase + 32'(k);
            wdata = d;
            wlast = (k == last_mark);
            @(negedge clk);
            ev = (cyc == nv);
            chk("wr_resp", 32'(o_wresp), 32'(ev));
            if (ev) begin
                idx = int'(((start >> 2) + 32'(k)) & 32'h3FF);
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) model[tgt][idx][8*b +: 8] = d[8*b +: 8];
                end
                k++;
                nv = cyc + gap + 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("wr_beats", 32'(k), 32'(len));
        wen    = 1'b0;
        wvalid = 1'b0;
        wlast  = 1'b0;
        @(negedge clk);
        chk("wr_idle", 32'(o_wresp), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] st;
        int          ln;
        ce = 1'b1; sel = 4'hF; ren = 1'b0; rready = 1'b0; wen = 1'b0; wvalid = 1'b0;
        wlast = 1'b0; tgt = 1'b0; rlen = '0; wlen = '0; raddr = '0; waddr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("init_rvalid", 32'(o_rvalid), 32'd0);
        chk("init_rdata", o_rdata, 32'd0);
        chk("init_wresp", 32'(o_wresp), 32'd0);
        chk("init_perr", 32'(o_perr), 32'd0);
        rst = 1'b0;

        // Directed line fill and read-back on the default instance.
        write_burst(32'h100, 8, 4'hF, 1'b0, 32'h1000, 7);
        read_burst(32'h100, 8, 0, -1);
        chk("perr_clean", 32'(o_perr), 32'd0);

        // Gapped instance, with rready stalls holding beats.
        tgt = 1'b1;
        write_burst(32'h100, 8, 4'hF, 1'b0, 32'h1000, 7);
        read_burst(32'h100, 8, 40, -1);
        chk("perr_gap", 32'(o_perr), 32'd0);
        tgt = 1'b0;

        // Chip enable low: requests are not started.
        ce  = 1'b0;
        ren = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ce_low_rvalid", 32'(o_rvalid), 32'd0);
        end
        @(posedge clk); #1;
        ren = 1'b0;
        ce  = 1'b1;

        fork
            read_burst(32'h100, 8, 0, -1);
            write_burst(32'h200, 8, 4'hF, 1'b1, 32'h0, 7);
        join
        read_burst(32'h200, 8, 0, -1);

        // Byte-lane merge onto an existing word.
        write_burst(32'h200, 1, 4'hF, 1'b0, 32'h1234_5678, 0);
        write_burst(32'h200, 1, 4'b0011, 1'b0, 32'hAAAA_5555, 0);
        read_burst(32'h200, 1, 0, -1);

        // Index wrap at the top of the array, upper address bits ignored.
        write_burst(32'hABCD_0FF8, 4, 4'hF, 1'b1, 32'h0, 3);
        read_burst(32'h0000_0FF8, 4, 25, -1);

        for (int i = 0; i < 6; i++) begin
            st = $urandom & 32'hFFFF_FFFC;
            ln = $urandom_range(16, 1);
            write_burst(st, ln, 4'hF, 1'b1, 32'h0, ln - 1);
            write_burst(st, ln, 4'($urandom_range(15, 1)), 1'b1, 32'h0, ln - 1);
            read_burst(st, ln, 30, -1);
        end
        chk("perr_random", 32'(o_perr), 32'd0);

        // Early wlast is a sticky protocol error.
        write_burst(32'h300, 8, 4'hF, 1'b1, 32'h0, 3);
        chk("perr_wlast", 32'(o_perr), 32'd1);
        read_burst(32'h300, 8, 0, -1);
        chk("perr_sticky", 32'(o_perr), 32'd1);

        // Reset mid-burst, then a clean burst afterwards.
        read_burst(32'h100, 8, 0, 4);
        @(posedge clk); #1;
        ren    = 1'b0;
        rready = 1'b0;
        rst    = 1'b0;
        read_burst(32'h100, 8, 20, -1);
        chk("perr_after_rst", 32'(o_perr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
